// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register with per-stage flush and optional 2-entry skid buffer.
// Optional statistics counters (stall_cnt/bubble_cnt) are built when PIPE_STAGE_BUF_STATS_EN is defined.
module pipe_stage_buf #(
   parameter int PAYLOAD_W = 64,
   parameter int SKID      = 1,
   parameter int CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data
`ifdef PIPE_STAGE_BUF_STATS_EN
   ,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   if (PAYLOAD_W < 1 || CNT_W < 1 || (SKID != 0 && SKID != 1)) begin : g_bad_param
      $error("pipe_stage_buf: illegal parameter combination");
   end

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PAYLOAD_W-1:0] r_main;
   logic [PAYLOAD_W-1:0] r_skid;
   logic                 w_in_fire;
   logic                 w_out_fire;
   logic                 w_load_main;
   logic                 w_main_from_skid;
   logic                 w_load_skid;

   assign out_valid  = (r_state != ST_EMPTY);
   assign out_data   = r_main;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_state_nxt = ST_HALF;
               w_load_main = 1'b1;
            end
         end
         ST_HALF: begin
            if (w_in_fire && w_out_fire) begin
               w_load_main = 1'b1;
            end else if (w_in_fire && SKID != 0) begin
               w_state_nxt = ST_FULL;
               w_load_skid = 1'b1;
            end else if (w_out_fire) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_out_fire) begin
               w_state_nxt      = ST_HALF;
               w_load_main      = 1'b1;
               w_main_from_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // Flush overrides everything; any payload arriving this cycle is dropped.
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_load_main = 1'b0;
         w_load_skid = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         // NOTE: payload registers are reset too, because out_data must read zero while in reset.
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_main) r_main <= w_main_from_skid ? r_skid : in_data;
         if (w_load_skid) r_skid <= in_data;
      end
   end

   if (SKID != 0) begin : g_skid_ready
      logic r_in_ready;
      always_ff @(posedge clk) begin
         if (!rst_n) r_in_ready <= 1'b0;
         else        r_in_ready <= (w_state_nxt != ST_FULL);
      end
      assign in_ready = r_in_ready;
   end else begin : g_comb_ready
      assign in_ready = rst_n & (~out_valid | out_ready);
   end

`ifdef PIPE_STAGE_BUF_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   // Saturating counters; only reset clears them, flush does not.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (!out_valid && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a SKID=1 and a SKID=0 (CNT_W=4) instance share one stimulus stream.
module tb_pipe_stage_buf;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         flush = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_data = '0;

   logic         s_in_ready, s_out_valid;
   logic [W-1:0] s_out_data;
   logic         n_in_ready, n_out_valid;
   logic [W-1:0] n_out_data;
`ifdef PIPE_STAGE_BUF_STATS_EN
   logic [31:0]  s_stall, s_bubble;
   logic [3:0]   n_stall, n_bubble;
`endif

   int           n_cmp = 0;
   int           n_fail = 0;
   int           n_out_s = 0;
   int           n_out_n = 0;
   logic [W-1:0] q_s[$];
   logic [W-1:0] q_n[$];

   always #5 clk = ~clk;

   pipe_stage_buf #(.PAYLOAD_W(W), .SKID(1), .CNT_W(32)) u_skid (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data)
`ifdef PIPE_STAGE_BUF_STATS_EN
      , .stall_cnt(s_stall), .bubble_cnt(s_bubble)
`endif
   );

   pipe_stage_buf #(.PAYLOAD_W(W), .SKID(0), .CNT_W(4)) u_noskid (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
      .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data)
`ifdef PIPE_STAGE_BUF_STATS_EN
      , .stall_cnt(n_stall), .bubble_cnt(n_bubble)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected payloads are queued when upstream hands them over; flush and reset drop them.
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         q_s.delete();
         q_n.delete();
      end else begin
         if (in_valid && s_in_ready) q_s.push_back(in_data);
         if (in_valid && n_in_ready) q_n.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (rst_n && s_out_valid && out_ready) begin
         n_out_s++;
         if (q_s.size() == 0) check("skid_extra_output", 32'(s_out_data), 32'hFFFF_FFFF);
         else                 check("skid_out_data", 32'(s_out_data), 32'(q_s.pop_front()));
      end
      if (rst_n && n_out_valid && out_ready) begin
         n_out_n++;
         if (q_n.size() == 0) check("noskid_extra_output", 32'(n_out_data), 32'hFFFF_FFFF);
         else                 check("noskid_out_data", 32'(n_out_data), 32'(q_n.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic         v_model;
      logic         acc;
      logic [15:0]  pat;
      logic [W-1:0] nxt;

      // Reset held with in_valid asserted.
      rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b1;
      repeat (3) begin
         step();
         check("rst_skid_out_valid", 32'(s_out_valid), 0);
         check("rst_skid_in_ready", 32'(s_in_ready), 0);
         check("rst_noskid_in_ready", 32'(n_in_ready), 0);
         check("rst_skid_out_data", 32'(s_out_data), 0);
      end
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      check("rel_noskid_in_ready", 32'(n_in_ready), 1);
      check("rel_skid_in_ready_first", 32'(s_in_ready), 0);
      step();
      check("rel_skid_in_ready_after", 32'(s_in_ready), 1);

      // Streaming 1..8 with out_ready held high.
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = W'(i);
         step();
         if (i == 1) begin
            check("lat_skid_out_valid", 32'(s_out_valid), 1);
            check("lat_skid_out_data", 32'(s_out_data), 1);
            check("lat_noskid_out_data", 32'(n_out_data), 1);
         end
      end
      in_valid = 1'b0;
      step();
      check("stream_skid_count", 32'(n_out_s), 8);
      check("stream_noskid_count", 32'(n_out_n), 8);

      // Backpressure: A and B accepted into main/skid, C stalls.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
      step();
      in_data = 16'h000B;
      step();
      in_data = 16'h000C;
      step();
      check("bp_full_in_ready", 32'(s_in_ready), 0);
      check("bp_hold_data", 32'(s_out_data), 32'h000A);
      step();
      check("bp_full_in_ready_2", 32'(s_in_ready), 0);
      check("bp_hold_data_2", 32'(s_out_data), 32'h000A);
      out_ready = 1'b1;
      step();
      check("bp_ready_rise", 32'(s_in_ready), 1);
      check("bp_second_data", 32'(s_out_data), 32'h000B);
      step();
      in_valid = 1'b0;
      step();
      step();
      check("bp_skid_count", 32'(n_out_s), 11);
      check("bp_skid_q_empty", 32'(q_s.size()), 0);

      // Flush while FULL with 0xD offered; 0xD must vanish, 0xE must pass.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0010;
      step();
      in_data = 16'h0011;
      step();
      check("fl_full_in_ready", 32'(s_in_ready), 0);
      in_data = 16'h000D; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_skid_out_valid", 32'(s_out_valid), 0);
      check("fl_skid_in_ready", 32'(s_in_ready), 1);
      check("fl_noskid_out_valid", 32'(n_out_valid), 0);
      in_valid = 1'b1; in_data = 16'h000E; out_ready = 1'b1;
      step();
      check("fl_next_data", 32'(s_out_data), 32'h000E);
      in_valid = 1'b0;
      step();
      check("fl_skid_count", 32'(n_out_s), 12);
      check("fl_skid_q_empty", 32'(q_s.size()), 0);

      // SKID=0 with out_ready toggling and a fixed irregular in_valid pattern.
      v_model = 1'b0;
      pat = 16'b1011_0110_1110_0101;
      nxt = 16'h0020;
      for (int c = 0; c < 16; c++) begin
         out_ready = (c % 2 == 0);
         in_valid = pat[c];
         in_data = nxt;
         @(negedge clk);
         check("s0_out_valid", 32'(n_out_valid), 32'(v_model));
         check("s0_in_ready", 32'(n_in_ready), 32'(!v_model || out_ready));
         acc = in_valid && (!v_model || out_ready);
         v_model = acc || (v_model && !out_ready);
         if (acc) nxt = nxt + 16'h0001;
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      check("s0_noskid_q_empty", 32'(q_n.size()), 0);
      check("s0_skid_q_empty", 32'(q_s.size()), 0);

`ifdef PIPE_STAGE_BUF_STATS_EN
      // Counters: exact stall count, saturation at CNT_W=4, bubbles after release.
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();
      step();
      check("st_rst_stall", s_stall, 0);
      rst_n = 1'b1; in_valid = 1'b1; in_data = 16'h0077;
      step();
      step();
      in_valid = 1'b0;
      repeat (5) step();
      check("st_stall_5", s_stall, 5);
      repeat (15) step();
      check("st_stall_20", s_stall, 20);
      check("st_stall_sat", 32'(n_stall), 15);
      check("st_skid_bubble", s_bubble, 2);
      check("st_noskid_bubble", 32'(n_bubble), 1);
      out_ready = 1'b1;
      repeat (2) step();
      check("st_skid_q_empty", 32'(q_s.size()), 0);
      check("st_noskid_q_empty", 32'(q_n.size()), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
